prompt_integrate_dump: RTL and testbench
========================================

Name: prompt_integrate_dump

Overview:
- Integrate-and-dump stage that consumes the 1-bit prompt_i/prompt_q correlator outputs of a tracking channel.
- Accumulates signed ±1 contributions over one code epoch, then dumps I/Q sums and the sample count into a held output register.
- The output register is read by the host/loop-filter side through a valid/ready handshake.
- Sits directly downstream of the channel, one instance per channel.

Parameters:
ACC_WIDTH  16  width of signed I/Q accumulators and dump outputs (two's complement)
CNT_WIDTH  16  width of unsigned sample counter and dump_count

Ports:
clk            input   1          system clock
reset          input   1          asynchronous active-high reset
enable         input   1          integrate enable; low = accumulators held cleared
sample_valid   input   1          prompt_i/prompt_q valid this cycle
prompt_i       input   1          in-phase prompt bit (0 = +1, 1 = -1)
prompt_q       input   1          quadrature prompt bit (0 = +1, 1 = -1)
epoch          input   1          single-cycle strobe marking end of integration period (C/A code wrap)
dump_ready     input   1          consumer accepts dump this cycle
clear_overrun  input   1          clears sticky overrun flag
dump_valid     output  1          dump registers hold an unconsumed result
dump_i         output  ACC_WIDTH  signed I sum of last period
dump_q         output  ACC_WIDTH  signed Q sum of last period
dump_count     output  CNT_WIDTH  samples integrated in last period
overrun        output  1          sticky: a dump was overwritten before being consumed

Behaviour:
- Reset (async, immediate): acc_i, acc_q, count, dump_i, dump_q, dump_count = 0; dump_valid = 0; overrun = 0.
- Contribution per cycle with enable && sample_valid: +1 if the prompt bit is 0, -1 if it is 1, applied independently to I and Q; count += 1.
- Accumulator arithmetic is saturating:
  - acc clamps to [-(2^(ACC_WIDTH-1)-1), +(2^(ACC_WIDTH-1)-1)], a symmetric range; the most negative code is never produced.
  - count saturates at all-ones.
- States:
  - IDLE (enable = 0): acc/count forced to 0; epoch ignored; dump registers and handshake keep operating.
  - INTEGRATE (enable = 1).
  - Transition IDLE -> INTEGRATE: first sample is counted on the first cycle enable is high.
  - Deasserting enable mid-period discards the partial sum; no dump occurs.
- Epoch in INTEGRATE:
  - Dump registers load acc + the coincident contribution (if sample_valid that cycle), saturated; dump_count loads count + 1 if sample_valid, else count.
  - acc/count restart at 0 on the next cycle.
  - dump_valid = 1 from the cycle after the epoch edge.
  - Latency: epoch edge -> dump_valid visible = 1 clock.
- Handshake:
  - dump_valid stays high and the dump registers stay stable until a cycle with dump_valid && dump_ready; dump_valid = 0 on the following edge unless a new epoch loads that same cycle.
  - dump_ready while dump_valid = 0 has no effect.
- Simultaneous events:
  - epoch && dump_valid && !dump_ready: dump registers overwritten with the new result, dump_valid stays 1, overrun set.
  - epoch && dump_valid && dump_ready: old result consumed, new one loaded, dump_valid stays 1, no overrun.
  - clear_overrun && an overrun-setting event in the same cycle: set wins, overrun = 1.
- Epochs on consecutive cycles are legal: the second dump carries the count of one or zero samples.
- Zero-sample period (epoch with count = 0 and no sample): dump of 0/0/0 is still produced.

Test Plan:
- Reset while mid-period with acc_i = 5 and dump_valid = 1 -> all outputs 0 asynchronously, before the next clk edge; counting resumes from 0 after release.
- 10 consecutive samples, prompt_i = 0 and prompt_q = 1, epoch on the 10th -> next cycle dump_valid = 1, dump_i = +10, dump_q = -10, dump_count = 10; with ready held low the values stay put for 5 cycles, then clear one cycle after ready.
- ACC_WIDTH = 4, 20 samples with prompt_i = 0 and prompt_q = 1, then epoch -> dump_i = +7, dump_q = -7, dump_count = 20.
- Two epochs 4 samples apart with dump_ready = 0 -> dump_count = 4 from the second period, overrun = 1; one-cycle clear_overrun -> overrun = 0, dump_valid still 1.
- dump_ready and epoch asserted in the same cycle while valid -> dump_valid never drops, new sums present, overrun = 0.
- 6 samples, then enable low for 3 cycles with an epoch pulsed inside that window, then enable high, 2 samples, epoch -> exactly one dump: dump_count = 2, dump_i = ±2.

Source files
------------

// File: rtl/prompt_integrate_dump.sv
// Integrate-and-dump for one tracking channel: sums 1-bit prompt I/Q as +/-1 over a
// code epoch and holds the result for a valid/ready consumer, flagging overwrites.
module prompt_integrate_dump #(
   parameter int ACC_WIDTH = 16,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 sample_valid,
   input  logic                 prompt_i,
   input  logic                 prompt_q,
   input  logic                 epoch,
   input  logic                 dump_ready,
   input  logic                 clear_overrun,
   output logic                 dump_valid,
   output logic [ACC_WIDTH-1:0] dump_i,
   output logic [ACC_WIDTH-1:0] dump_q,
   output logic [CNT_WIDTH-1:0] dump_count,
   output logic                 overrun
);

   // Symmetric clamp limits, one bit wider than the accumulators so overflow is visible.
   localparam logic signed [ACC_WIDTH:0] ACC_MAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH:0] ACC_MIN = {2'b11, {(ACC_WIDTH-2){1'b0}}, 1'b1};
   localparam logic signed [ACC_WIDTH:0] ONE     = {{ACC_WIDTH{1'b0}}, 1'b1};

   logic [ACC_WIDTH-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic [ACC_WIDTH-1:0] dump_i_q, dump_i_d, dump_q_q, dump_q_d;
   logic [CNT_WIDTH-1:0] dump_count_q, dump_count_d;
   logic                 dump_valid_q, dump_valid_d;
   logic                 overrun_q, overrun_d;

   logic                 active;
   logic                 dump_load;
   logic [ACC_WIDTH-1:0] sum_i, sum_q;
   logic [CNT_WIDTH-1:0] count_next;

   // A set prompt bit means -1, a clear bit +1.
   function automatic logic [ACC_WIDTH-1:0] sat_step(input logic [ACC_WIDTH-1:0] acc,
                                                     input logic active_in,
                                                     input logic bit_in);
      logic signed [ACC_WIDTH:0] wide;
      wide = $signed({acc[ACC_WIDTH-1], acc});
      if (active_in) begin
         wide = bit_in ? (wide - ONE) : (wide + ONE);
      end
      if (wide > ACC_MAX) begin
         wide = ACC_MAX;
      end else if (wide < ACC_MIN) begin
         wide = ACC_MIN;
      end
      return wide[ACC_WIDTH-1:0];
   endfunction

   always_comb begin
      active     = enable & sample_valid;
      dump_load  = enable & epoch;
      sum_i      = sat_step(acc_i_q, active, prompt_i);
      sum_q      = sat_step(acc_q_q, active, prompt_q);
      count_next = count_q;
      if (active && (count_q != {CNT_WIDTH{1'b1}})) begin
         count_next = count_q + CNT_WIDTH'(1);
      end
   end

   // The epoch cycle's own sample goes into the dump; the running sums restart at zero.
   always_comb begin
      acc_i_d = sum_i;
      acc_q_d = sum_q;
      count_d = count_next;
      if (!enable || epoch) begin
         acc_i_d = '0;
         acc_q_d = '0;
         count_d = '0;
      end
   end

   always_comb begin
      dump_i_d     = dump_i_q;
      dump_q_d     = dump_q_q;
      dump_count_d = dump_count_q;
      if (dump_load) begin
         dump_i_d     = sum_i;
         dump_q_d     = sum_q;
         dump_count_d = count_next;
      end
      dump_valid_d = dump_load | (dump_valid_q & ~dump_ready);
      overrun_d    = (dump_load & dump_valid_q & ~dump_ready) | (overrun_q & ~clear_overrun);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_i_q      <= '0;
         acc_q_q      <= '0;
         count_q      <= '0;
         dump_i_q     <= '0;
         dump_q_q     <= '0;
         dump_count_q <= '0;
         dump_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         acc_i_q      <= acc_i_d;
         acc_q_q      <= acc_q_d;
         count_q      <= count_d;
         dump_i_q     <= dump_i_d;
         dump_q_q     <= dump_q_d;
         dump_count_q <= dump_count_d;
         dump_valid_q <= dump_valid_d;
         overrun_q    <= overrun_d;
      end
   end

   assign dump_valid = dump_valid_q;
   assign dump_i     = dump_i_q;
   assign dump_q     = dump_q_q;
   assign dump_count = dump_count_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_prompt_integrate_dump.sv
// Directed bench for prompt_integrate_dump: a small integrate model pushes expected dumps
// to a scoreboard queue; a 4-bit instance shares the inputs to exercise saturation.
module tb_prompt_integrate_dump;

   typedef struct {
      int i;
      int q;
      int c;
   } dump_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        sample_valid = 1'b0;
   logic        prompt_i = 1'b0;
   logic        prompt_q = 1'b0;
   logic        epoch = 1'b0;
   logic        dump_ready = 1'b0;
   logic        clear_overrun = 1'b0;
   logic        dump_valid, overrun, dump_valid4, overrun4;
   logic [15:0] dump_i, dump_q, dump_count, dump_count4;
   logic [3:0]  dump_i4, dump_q4;

   int    checks = 0;
   int    errors = 0;
   int    m_i = 0;
   int    m_q = 0;
   int    m_c = 0;
   dump_t sb[$];

   always #5 clk = ~clk;

   prompt_integrate_dump #(.ACC_WIDTH(16), .CNT_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid),
      .prompt_i(prompt_i), .prompt_q(prompt_q), .epoch(epoch), .dump_ready(dump_ready),
      .clear_overrun(clear_overrun), .dump_valid(dump_valid), .dump_i(dump_i),
      .dump_q(dump_q), .dump_count(dump_count), .overrun(overrun)
   );

   prompt_integrate_dump #(.ACC_WIDTH(4), .CNT_WIDTH(16)) dut4 (
      .clk(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid),
      .prompt_i(prompt_i), .prompt_q(prompt_q), .epoch(epoch), .dump_ready(dump_ready),
      .clear_overrun(clear_overrun), .dump_valid(dump_valid4), .dump_i(dump_i4),
      .dump_q(dump_q4), .dump_count(dump_count4), .overrun(overrun4)
   );

   function automatic int sat(input int v, input int lim);
      if (v > lim) return lim;
      if (v < -lim) return -lim;
      return v;
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one clock of inputs, advance the reference model, return #1 after the edge.
   task automatic cyc(input logic en, input logic sv, input logic pi, input logic pq,
                      input logic ep, input logic rdy, input logic clr);
      int ni, nq, nc;
      enable = en; sample_valid = sv; prompt_i = pi; prompt_q = pq;
      epoch = ep; dump_ready = rdy; clear_overrun = clr;
      if (!en) begin
         m_i = 0; m_q = 0; m_c = 0;
      end else begin
         ni = sv ? sat(m_i + (pi ? -1 : 1), 32767) : m_i;
         nq = sv ? sat(m_q + (pq ? -1 : 1), 32767) : m_q;
         nc = (sv && m_c < 65535) ? m_c + 1 : m_c;
         if (ep) begin
            sb.push_back('{ni, nq, nc});
            m_i = 0; m_q = 0; m_c = 0;
         end else begin
            m_i = ni; m_q = nq; m_c = nc;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_dump(input string tag);
      dump_t e;
      checks++;
      assert (sb.size() > 0) else begin
         errors++;
         $error("FAIL %s_sb observed empty expected entry", tag);
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, "_valid"}, int'(dump_valid), 1);
         check({tag, "_i"}, int'($signed(dump_i)), e.i);
         check({tag, "_q"}, int'($signed(dump_q)), e.q);
         check({tag, "_count"}, int'(dump_count), e.c);
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", int'(dump_valid), 0);
      check("rst_i", int'(dump_i), 0);
      check("rst_overrun", int'(overrun), 0);
      reset = 1'b0;
      cyc(0, 0, 0, 0, 0, 0, 0);

      // 20 samples: 16-bit reaches +/-20, 4-bit clamps at +/-7.
      for (int k = 0; k < 20; k++) cyc(1, 1, 0, 1, k == 19, 0, 0);
      check_dump("sat16");
      check("sat4_i", int'($signed(dump_i4)), 7);
      check("sat4_q", int'($signed(dump_q4)), -7);
      check("sat4_count", int'(dump_count4), 20);
      cyc(1, 0, 0, 0, 0, 1, 0);
      check("sat_consumed", int'(dump_valid), 0);

      // Ten samples then hold the dump with ready low.
      for (int k = 0; k < 10; k++) cyc(1, 1, 0, 1, k == 9, 0, 0);
      check_dump("ten");
      for (int k = 0; k < 5; k++) begin
         cyc(1, 0, 0, 0, 0, 0, 0);
         check("hold_valid", int'(dump_valid), 1);
         check("hold_i", int'($signed(dump_i)), 10);
      end
      cyc(1, 0, 0, 0, 0, 1, 0);
      check("ten_consumed", int'(dump_valid), 0);
      cyc(1, 0, 0, 0, 0, 1, 0);
      check("ready_idle", int'(dump_valid), 0);

      // Zero-sample period, then five samples before an asynchronous reset.
      cyc(1, 0, 0, 0, 1, 0, 0);
      check_dump("zero");
      for (int k = 0; k < 5; k++) cyc(1, 1, 0, 0, 0, 0, 0);
      #2 reset = 1'b1;
      #1;
      check("arst_valid", int'(dump_valid), 0);
      check("arst_i", int'(dump_i), 0);
      check("arst_count", int'(dump_count), 0);
      sb.delete();
      m_i = 0; m_q = 0; m_c = 0;
      #2 reset = 1'b0;
      for (int k = 0; k < 3; k++) cyc(1, 1, 0, 0, k == 2, 0, 0);
      check_dump("post_rst");
      cyc(1, 0, 0, 0, 0, 1, 0);

      // Two epochs with no consumer in between.
      for (int k = 0; k < 3; k++) cyc(1, 1, 1, 0, k == 2, 0, 0);
      check_dump("ovr_first");
      for (int k = 0; k < 4; k++) cyc(1, 1, k[0], 0, k == 3, 0, 0);
      check_dump("ovr_second");
      check("ovr_set", int'(overrun), 1);
      cyc(1, 0, 0, 0, 0, 0, 1);
      check("ovr_cleared", int'(overrun), 0);
      check("ovr_valid_kept", int'(dump_valid), 1);

      // Consume and load in the same cycle.
      for (int k = 0; k < 3; k++) begin
         cyc(1, 1, 1, 1, 0, 0, 0);
         check("swap_valid", int'(dump_valid), 1);
      end
      cyc(1, 1, 1, 0, 1, 1, 0);
      check_dump("swap");
      check("swap_overrun", int'(overrun), 0);
      cyc(1, 0, 0, 0, 0, 1, 0);
      check("swap_consumed", int'(dump_valid), 0);

      // Partial period discarded by enable low; the epoch inside the window is ignored.
      for (int k = 0; k < 6; k++) cyc(1, 1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         cyc(0, 1, 0, 0, k == 1, 0, 0);
         check("idle_no_dump", int'(dump_valid), 0);
      end
      cyc(1, 1, 1, 0, 0, 0, 0);
      cyc(1, 1, 1, 0, 1, 0, 0);
      check_dump("discard");
      check("discard_sb_empty", sb.size(), 0);

      // Overrun set and clear in the same cycle: set wins.
      cyc(1, 0, 0, 0, 1, 0, 1);
      check_dump("setwins");
      check("setwins_overrun", int'(overrun), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
